// File: rtl/adder_scheduler_if.sv
// Request/operand/result bundle shared between two requesters and the adder scheduler.
interface adder_scheduler_if #(
  parameter int BITS = 32
);
  logic                req0;
  logic                req1;
  logic [2*BITS-1:0]   a0;
  logic [2*BITS-1:0]   b0;
  logic [2*BITS-1:0]   a1;
  logic [2*BITS-1:0]   b1;
  logic                sub0;
  logic                sub1;
  logic                gnt0;
  logic                gnt1;
  logic                busy;
  logic                res_valid;
  logic                res_id;
  logic [2*BITS-1:0]   res;
  logic                res_cout;
  logic                res_ovf;

  modport master (
    output req0, req1, a0, b0, a1, b1, sub0, sub1,
    input  gnt0, gnt1, busy, res_valid, res_id, res, res_cout, res_ovf
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sub0, sub1,
    output gnt0, gnt1, busy, res_valid, res_id, res, res_cout, res_ovf
  );
endinterface

// File: rtl/adder_scheduler.sv
// Two-requester add/sub engine: one BITS-wide ripple adder reused for the low
// and high halves of a 2*BITS operation, round-robin arbitration, one op per 4 cycles.
module adder_scheduler_rca #(
  parameter int BITS = 32
) (
  input  logic            i_cin,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic [BITS-1:0] o_s,
  output logic            o_cout
);
  logic [BITS:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < BITS; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[BITS];
endmodule

module adder_scheduler #(
  parameter int BITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_scheduler_if.slave   bus
);
  localparam int W = 2 * BITS;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_ptr;
  logic            r_id;
  logic            r_sub;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [BITS-1:0] r_lo_sum;
  logic            r_lo_c;

  logic [W-1:0]    r_res;
  logic            r_res_id;
  logic            r_res_cout;
  logic            r_res_ovf;

  logic            w_any;
  logic            w_win;
  logic            w_cin;
  logic [BITS-1:0] w_add_a;
  logic [BITS-1:0] w_add_b;
  logic [BITS-1:0] w_sum;
  logic            w_cout;

  function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_any = bus.req0 | bus.req1;
  // On a tie the requester not served last wins; otherwise the lone requester wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_ptr : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    bus.res_valid = (r_state == S_DONE);
    if (r_state == S_LO) begin
      bus.gnt0 = ~r_id;
      bus.gnt1 = r_id;
    end
  end

  // Word select for the shared adder: low half in LO, high half otherwise.
  always_comb begin
    w_add_a = r_a[BITS-1:0];
    w_add_b = r_b[BITS-1:0];
    w_cin   = r_sub;
    if (r_state == S_HI) begin
      w_add_a = r_a[W-1:BITS];
      w_add_b = r_b[W-1:BITS];
      w_cin   = r_lo_c;
    end
  end

  adder_scheduler_rca #(.BITS(BITS)) u_rca (
    .i_cin  (w_cin),
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b1;
      r_id       <= 1'b0;
      r_res      <= '0;
      r_res_id   <= 1'b0;
      r_res_cout <= 1'b0;
      r_res_ovf  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_ptr <= w_win;
        r_id  <= w_win;
      end
      if (r_state == S_HI) begin
        r_res      <= {w_sum, r_lo_sum};
        r_res_id   <= r_id;
        r_res_cout <= w_cout;
        r_res_ovf  <= f_ovf(r_a[W-1], r_b[W-1], w_sum[BITS-1]);
      end
    end
  end

  // Operand and partial-sum registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_any) begin
      r_a   <= w_win ? bus.a1 : bus.a0;
      r_b   <= w_win ? (bus.sub1 ? ~bus.b1 : bus.b1) : (bus.sub0 ? ~bus.b0 : bus.b0);
      r_sub <= w_win ? bus.sub1 : bus.sub0;
    end
    if (r_state == S_LO) begin
      r_lo_sum <= w_sum;
      r_lo_c   <= w_cout;
    end
  end

  assign bus.res      = r_res;
  assign bus.res_id   = r_res_id;
  assign bus.res_cout = r_res_cout;
  assign bus.res_ovf  = r_res_ovf;
endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter BITS, default 32, width of the single shared adder datapath; operands and results are 2*BITS wide.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  2*BITS each  operands of requester 0 / 1.
REQ-007 sub0, sub1  input  1 each  1 = compute a-b, 0 = compute a+b.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 res_valid  output  1  one-cycle pulse: res, res_id, res_cout, res_ovf valid.
REQ-011 res_id  output  1  requester index of the current result.
REQ-012 res  output  2*BITS  sum/difference.
REQ-013 res_cout  output  1  carry out of bit 2*BITS-1 (for sub: 1 = no borrow).
REQ-014 res_ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Block SHALL contain exactly one BITS-wide ripple adder instance (Cin, A, B -> S, Cout), time-multiplexed over low and high words.
REQ-016 FSM states: IDLE, LO, HI, DONE; IDLE->LO on any sampled request; LO->HI, HI->DONE, DONE->IDLE unconditionally.
REQ-017 Requests SHALL be sampled only in IDLE; requests in LO/HI/DONE are ignored but remain pending if held.
REQ-018 Arbitration round-robin: if only one request, serve it; if both, serve the requester not served last; last-served pointer resets to 1 so req0 wins the first tie.
REQ-019 On IDLE->LO edge: capture winner's a, b (b bitwise inverted if sub), sub, id; update pointer; gnt of winner high for exactly the LO cycle.
REQ-020 LO: adder computes low BITS with Cin = sub; low sum and carry registered.
REQ-021 HI: adder computes high BITS with Cin = registered low carry; high sum and carry registered.
REQ-022 DONE: res_valid = 1 for exactly this cycle; res, res_id, res_cout, res_ovf updated entering DONE and held until next DONE.
REQ-023 res_ovf = (a[MSB] == b'[MSB]) and (res[MSB] != a[MSB]), b' = operand after inversion.
REQ-024 Latency: request sampled at edge k -> gnt high cycle k+1 -> res_valid high cycle k+3; next sample earliest at edge k+4 (one op per 4 cycles).
REQ-025 Requester SHALL deassert req or change operands only after its gnt; req still high at next IDLE is a new request.
REQ-026 gnt0 and gnt1 SHALL never be high simultaneously; at most one operation in flight.
REQ-027 Operand changes after capture SHALL not affect the in-flight result.

Reset
REQ-028 rst_n low, any state (including mid-operation) SHALL immediately force IDLE, abort the operation, pointer = 1, and drive gnt0, gnt1, busy, res_valid, res_id, res, res_cout, res_ovf to 0.
REQ-029 An aborted operation SHALL never produce res_valid; first sample after rst_n rises is the first clk edge with rst_n high.

Verification (BITS = 32)
REQ-030 req0, a0=0x00000000_FFFFFFFF, b0=1, sub0=0 -> gnt0 at k+1, res_valid at k+3, res=0x00000001_00000000, res_cout=0, res_ovf=0, res_id=0.
REQ-031 req1, a1=0, b1=1, sub1=1 -> res=0xFFFFFFFF_FFFFFFFF, res_cout=0, res_ovf=0, res_id=1.
REQ-032 req0, a0=0x7FFFFFFF_FFFFFFFF, b0=1, add -> res=0x80000000_00000000, res_ovf=1, res_cout=0; a0=0xFFFFFFFF_FFFFFFFF, b0=1 -> res=0, res_cout=1, res_ovf=0.
REQ-033 req0 and req1 held high from reset release -> gnt0 first, gnt1 four cycles later, then gnt0; res_id sequence 0,1,0; never both gnt high.
REQ-034 rst_n pulsed low during HI of a req0 operation -> all outputs 0 at once, no res_valid; after release, req1 only with 5+3 -> gnt1, res=8, res_id=1.
REQ-035 Operands of granted requester changed during LO/HI -> result reflects captured values only.
